// File: rtl/ascii_result_tx.sv
// ascii_result_tx: converts an 8-bit result to decimal ASCII and streams it byte by byte to a UART TX
module ascii_result_tx #(
    parameter bit         SEND_NEWLINE = 1'b1,
    parameter logic [7:0] NEWLINE_CHAR = 8'h0A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] value,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_done_tick,
    output logic       busy,
    output logic       done_tick
);

    typedef enum logic [2:0] {IDLE, CONV_H, CONV_T, LOAD, SEND, WAIT, DONE} state_t;

    state_t     state;
    logic [7:0] rem;
    logic [1:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [1:0] idx;
    logic [2:0] nchar;
    logic [2:0] ndig;
    logic [7:0] chars [4];
    logic [7:0] clist [4];
    logic [7:0] h_c;
    logic [7:0] t_c;
    logic [7:0] o_c;

    assign h_c = 8'h30 | {6'b0, hund};
    assign t_c = 8'h30 | {4'b0, tens};
    assign o_c = 8'h30 | {4'b0, ones};

    // Character list with leading zeros dropped; the terminator slot follows the last digit
    always_comb begin
        clist = '{o_c, NEWLINE_CHAR, 8'h00, 8'h00};
        ndig  = 3'd1;
        if (hund != 2'd0) begin
            clist = '{h_c, t_c, o_c, NEWLINE_CHAR};
            ndig  = 3'd3;
        end else if (tens != 4'd0) begin
            clist = '{t_c, o_c, NEWLINE_CHAR, 8'h00};
            ndig  = 3'd2;
        end
    end

    // Conversion and transmit sequencer; every output is registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rem       <= 8'h00;
            hund      <= 2'd0;
            tens      <= 4'd0;
            ones      <= 4'd0;
            idx       <= 2'd0;
            nchar     <= 3'd0;
            chars     <= '{default: 8'h00};
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
            busy      <= 1'b0;
            done_tick <= 1'b0;
        end else begin
            tx_start  <= 1'b0;
            done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rem   <= value;
                        hund  <= 2'd0;
                        tens  <= 4'd0;
                        busy  <= 1'b1;
                        state <= CONV_H;
                    end
                end
                CONV_H: begin
                    if (rem >= 8'd100) begin
                        rem  <= rem - 8'd100;
                        hund <= hund + 2'd1;
                    end else begin
                        state <= CONV_T;
                    end
                end
                CONV_T: begin
                    if (rem >= 8'd10) begin
                        rem  <= rem - 8'd10;
                        tens <= tens + 4'd1;
                    end else begin
                        ones  <= rem[3:0];
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    chars <= clist;
                    nchar <= ndig + {2'b00, SEND_NEWLINE};
                    idx   <= 2'd0;
                    state <= SEND;
                end
                SEND: begin
                    tx_data  <= chars[idx];
                    tx_start <= 1'b1;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (tx_done_tick) begin
                        if ({1'b0, idx} == nchar - 3'd1) begin
                            done_tick <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= SEND;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_result_tx.sv
// tb_ascii_result_tx: directed checks of ascii_result_tx with and without the line terminator
module tb_ascii_result_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_x;
    logic       sel;
    logic [7:0] value;
    logic       tx_done_tick;
    logic [7:0] tx_data0, tx_data1;
    logic       tx_start0, tx_start1, busy0, busy1, done0, done1;
    logic       m_tx_start, m_busy, m_done;
    logic [7:0] m_tx_data;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    ascii_result_tx u_nl (
        .clk(clk), .reset(reset), .start(start_x & ~sel), .value(value),
        .tx_data(tx_data0), .tx_start(tx_start0), .tx_done_tick(tx_done_tick),
        .busy(busy0), .done_tick(done0)
    );

    ascii_result_tx #(.SEND_NEWLINE(1'b0)) u_nonl (
        .clk(clk), .reset(reset), .start(start_x & sel), .value(value),
        .tx_data(tx_data1), .tx_start(tx_start1), .tx_done_tick(tx_done_tick),
        .busy(busy1), .done_tick(done1)
    );

    assign m_tx_start = sel ? tx_start1 : tx_start0;
    assign m_busy     = sel ? busy1 : busy0;
    assign m_done     = sel ? done1 : done0;
    assign m_tx_data  = sel ? tx_data1 : tx_data0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one transaction, answering each tx_start with tx_done_tick dly cycles later
    task automatic xfer(input string tag, input logic [7:0] v, input int n, input logic [31:0] exp,
                        input int first, input int dly, input bit inj);
        logic [7:0] got [8];
        int cyc = 0, nb = 0, nd = 0, cd = 0;
        bit finished = 0;
        for (int i = 0; i < 8; i++) got[i] = 8'h00;
        value = v;
        start_x = 1'b1;
        @(posedge clk); #1;
        start_x = 1'b0;
        chk({tag, "_busy_rise"}, m_busy, 1);
        if (inj) tx_done_tick = 1'b1;
        while (cyc < 300 && !finished) begin
            @(posedge clk); #1;
            cyc++;
            start_x = inj && cyc == 2;
            if (inj && cyc == 2) value = 8'd99;
            if (cd > 0) begin
                cd--;
                tx_done_tick = (cd == 0);
            end else begin
                tx_done_tick = 1'b0;
            end
            if (m_tx_start) begin
                if (nb == 0 && first > 0) chk({tag, "_first_lat"}, cyc, first);
                if (nb < 8) got[nb] = m_tx_data;
                nb++;
                cd = dly;
            end
            if (m_done) begin
                nd++;
                chk({tag, "_busy_at_done"}, m_busy, 1);
            end
            if (nd > 0 && !m_busy) finished = 1;
        end
        start_x = 1'b0;
        tx_done_tick = 1'b0;
        chk({tag, "_finished"}, finished, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (m_tx_start) nb++;
            if (m_done) nd++;
        end
        chk({tag, "_nbytes"}, nb, n);
        chk({tag, "_ndone"}, nd, 1);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_byte%0d", tag, i), got[i], exp[31 - 8 * i -: 8]);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        start_x = 1'b0;
        sel = 1'b0;
        value = 8'h00;
        tx_done_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_start", tx_start0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_tx_data", tx_data0, 8'h00);
        chk("rst_busy_nonl", busy1, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        xfer("v0", 8'd0, 2, 32'h300A_0000, 4, 3, 0);
        xfer("v255", 8'd255, 4, 32'h3235_350A, 11, 5, 0);
        xfer("v105", 8'd105, 4, 32'h3130_350A, 0, 2, 0);
        xfer("v10", 8'd10, 3, 32'h3130_0A00, 0, 1, 0);

        sel = 1'b1;
        xfer("nonl_v7", 8'd7, 1, 32'h3700_0000, 4, 3, 0);
        sel = 1'b0;

        xfer("v42_ignore", 8'd42, 3, 32'h3432_0A00, 0, 4, 1);

        value = 8'd255;
        start_x = 1'b1;
        @(posedge clk); #1;
        start_x = 1'b0;
        cyc = 0;
        while (cyc < 40 && !tx_start0) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst_wait_first_byte", tx_start0, 1);
        chk("rst_wait_byte_val", tx_data0, 8'h32);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy", busy0, 0);
        chk("midrst_tx_start", tx_start0, 0);
        chk("midrst_done", done0, 0);
        chk("midrst_tx_data", tx_data0, 8'h00);
        @(posedge clk); #1;
        chk("midrst_done_next", done0, 0);

        xfer("v8_after_rst", 8'd8, 2, 32'h380A_0000, 4, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
